// File: rtl/apb_pkg.sv
// apb_pkg: APB types shared by the completer and the bus initiator.
// FSM state encoding, word shift and index-width helper.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state;

  localparam int APB_WORD_SHIFT = 2;
  localparam int APB_MAX_WAIT   = 15;
  localparam int APB_CNT_W      = 4;

  function automatic int apb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_slv_decode.sv
// apb_slv_decode: byte address -> register index and error flag.
// Ports: addr in, idx out (word index), err out (misaligned/out of range).
module apb_slv_decode
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = apb_idx_w(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);

  localparam int WW = ADDR_WIDTH - APB_WORD_SHIFT;

  logic [WW-1:0] word;
  logic          misal;
  logic          range;

  assign word  = addr[ADDR_WIDTH-1:APB_WORD_SHIFT];
  assign idx   = word[IDX_W-1:0];
  assign misal = addr[APB_WORD_SHIFT-1:0] != '0;
  // full word index compared so aliases above NUM_REGS are rejected
  assign range = word >= WW'(NUM_REGS);
  assign err   = misal | range;

endmodule

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer serving NUM_REGS read/write registers
// with WAIT_STATES wait cycles and PSLVERR on bad accesses.
// Ports: pclk, i_preset (sync, active-high), i_psel, i_penable,
// i_pwrite, i_paddr, i_pwdata, i_pstrb (only with APB_SLV_PSTRB_EN),
// o_prdata, o_pready, o_pslverr, o_regs (flat register contents).
// Macro APB_SLV_PSTRB_EN: byte strobes on writes, reads need pstrb=0.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           pclk,
  input  logic                           i_preset,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [ADDR_WIDTH-1:0]          i_paddr,
  input  logic [DATA_WIDTH-1:0]          i_pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
`endif
  output logic [DATA_WIDTH-1:0]          o_prdata,
  output logic                           o_pready,
  output logic                           o_pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int IDX_W = apb_idx_w(NUM_REGS);

  if (WAIT_STATES < 0 || WAIT_STATES > APB_MAX_WAIT) begin : g_ws_chk
    $error("WAIT_STATES out of range 0..15");
  end

  apb_state              state_q;
  logic [APB_CNT_W-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         strb_q;
  logic [SW-1:0]         strb_in;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic [IDX_W-1:0]      idx;
  logic                  dec_err;
  logic                  strb_err;
  logic                  err;
  logic                  done;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] rsel;

`ifdef APB_SLV_PSTRB_EN
  assign strb_in  = i_pstrb;
  assign strb_err = !wr_q && (strb_q != '0);
`else
  assign strb_in  = '1;
  assign strb_err = 1'b0;
`endif

  apb_slv_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr (addr_q),
    .idx  (idx),
    .err  (dec_err)
  );

  assign err = dec_err | strb_err;

  // completion is gated by psel so a dropped select never shows ready
  assign done = (state_q == ST_ACCESS) && i_psel && (cnt_q == '0);

  assign rsel      = regs_q[idx];
  assign o_pready  = done;
  assign o_pslverr = done && err;
  assign o_prdata  = (done && !err && !wr_q) ? rsel : '0;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < SW; b++) begin
      wmask[b*8 +: 8] = {8{strb_q[b]}};
    end
  end

  always_ff @(posedge pclk) begin
    if (i_preset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_psel && !i_penable) begin
            addr_q  <= i_paddr;
            wr_q    <= i_pwrite;
            wdata_q <= i_pwdata;
            strb_q  <= strb_in;
            cnt_q   <= APB_CNT_W'(WAIT_STATES);
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!i_psel) begin
            state_q <= ST_IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (i_preset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
    end else if (done && wr_q && !err) begin
      regs_q[idx] <= (rsel & ~wmask) | (wdata_q & wmask);
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign o_regs[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

endmodule
